// File: rtl/md_pkg.sv
// Shared opcodes, FSM state type and opcode classification helpers for the
// EX-stage multiply/divide unit.
package md_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;
  localparam logic [3:0] OP_MFHI  = 4'd11;
  localparam logic [3:0] OP_MFLO  = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  // Long ops occupy the unit for a latency window and commit to HI/LO at its end.
  function automatic logic is_long_op(input logic [3:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational result generator: maps (op, A, B, HI, LO) to the values that
// will be committed to HI/LO when the operation's latency expires.
module md_compute
  import md_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  output logic [W-1:0] pend_hi,
  output logic [W-1:0] pend_lo
);

  logic [2*W-1:0]        prod_s;
  logic [2*W-1:0]        prod_u;
  logic [2*W-1:0]        acc;
  logic [2*W-1:0]        res;
  logic                  b_zero;
  logic                  s_ovf;
  logic [W-1:0]          b_safe;
  logic signed [W-1:0]   q_s;
  logic signed [W-1:0]   r_s;
  logic [W-1:0]          q_u;
  logic [W-1:0]          r_u;

  assign acc    = {hi, lo};
  assign prod_s = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
  assign prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  assign b_zero = (b == '0);
  assign s_ovf  = (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
  // The divider never sees the two special cases, so no X or trap escapes it.
  assign b_safe = (b_zero || s_ovf) ? W'(1) : b;

  assign q_s = $signed(a) / $signed(b_safe);
  assign r_s = $signed(a) % $signed(b_safe);
  assign q_u = a / b_safe;
  assign r_u = a % b_safe;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    res = acc;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_MADD:  res = acc + prod_s;
      OP_MADDU: res = acc + prod_u;
      OP_MSUB:  res = acc - prod_s;
      OP_MSUBU: res = acc - prod_u;
      OP_DIV: begin
        if (b_zero)     res = {a, {W{1'b1}}};
        else if (s_ovf) res = {{W{1'b0}}, a};
        else            res = {r_s, q_s};
      end
      OP_DIVU: begin
        if (b_zero) res = {a, {W{1'b1}}};
        else        res = {r_u, q_u};
      end
      default: res = acc;
    endcase
  end

  assign pend_hi = res[2*W-1:W];
  assign pend_lo = res[W-1:0];

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with private HI/LO: one long op per accepted start,
// busy for a per-class latency, commit to HI/LO at the end unless flushed.
module md_unit
  import md_pkg::*;
#(
  parameter int W           = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         start,
  input  logic [3:0]   HiLoOp,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic         busy,
  output logic         state,
  output logic         done
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e     fsm, fsm_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          accept, commit;
  logic [W-1:0]  hi, lo, pend_hi, pend_lo;
  logic [W-1:0]  comp_hi, comp_lo;

  md_compute #(.W(W)) u_compute (
    .op      (HiLoOp),
    .a       (A),
    .b       (B),
    .hi      (hi),
    .lo      (lo),
    .pend_hi (comp_hi),
    .pend_lo (comp_lo)
  );

  always_comb begin
    fsm_next = fsm;
    cnt_next = cnt;
    accept   = 1'b0;
    commit   = 1'b0;
    case (fsm)
      IDLE: begin
        if (start && !flush && is_long_op(HiLoOp)) begin
          accept = 1'b1;
          if (is_div_op(HiLoOp)) begin
            fsm_next = DIV;
            cnt_next = CW'(DIV_CYCLES);
          end else begin
            fsm_next = MUL;
            cnt_next = CW'(MULT_CYCLES);
          end
        end
      end
      MUL, DIV: begin
        // Flush wins over completion, so a flush in the last busy cycle cancels the commit.
        if (flush) begin
          fsm_next = IDLE;
          cnt_next = '0;
        end else if (cnt == CW'(1)) begin
          fsm_next = IDLE;
          cnt_next = '0;
          commit   = 1'b1;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: begin
        fsm_next = IDLE;
        cnt_next = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm  <= IDLE;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      fsm  <= fsm_next;
      cnt  <= cnt_next;
      done <= commit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      if (accept) begin
        pend_hi <= comp_hi;
        pend_lo <= comp_lo;
      end
      if (commit) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end else if (fsm == IDLE && start && !flush) begin
        if (HiLoOp == OP_MTHI) hi <= A;
        if (HiLoOp == OP_MTLO) lo <= A;
      end
    end
  end

  assign busy  = (fsm != IDLE);
  assign state = busy | (start & is_long_op(HiLoOp));
  assign C     = (HiLoOp == OP_MFHI) ? hi :
                 (HiLoOp == OP_MFLO) ? lo : '0;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit (W=32, MULT_CYCLES=5, DIV_CYCLES=10) against
// an arithmetic model of HI/LO built from 64-bit integer operations.
module tb_md_unit;
  import md_pkg::*;

  localparam int LAT_MUL = 5;
  localparam int LAT_DIV = 10;

  logic        clk = 1'b0;
  logic        reset, flush, start;
  logic [3:0]  HiLoOp;
  logic [31:0] A, B, C;
  logic        busy, state, done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_unit #(.W(32), .MULT_CYCLES(LAT_MUL), .DIV_CYCLES(LAT_DIV)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .start  (start),
    .HiLoOp (HiLoOp),
    .A      (A),
    .B      (B),
    .C      (C),
    .busy   (busy),
    .state  (state),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Reference: what {HI,LO} should become after op, from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
    longint      sp;
    logic [63:0] up, acc;
    int          q, r;
    sp  = longint'($signed(a)) * longint'($signed(b));
    up  = 64'(a) * 64'(b);
    acc = {hi, lo};
    case (op)
      OP_MULT:  return sp;
      OP_MULTU: return up;
      OP_MADD:  return acc + sp;
      OP_MADDU: return acc + up;
      OP_MSUB:  return acc - sp;
      OP_MSUBU: return acc - up;
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      OP_MTHI:  return {a, lo};
      OP_MTLO:  return {hi, a};
      default:  return acc;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op);
    return (op == OP_DIV || op == OP_DIVU) ? LAT_DIV : LAT_MUL;
  endfunction

  // Caller is at a falling edge; start is held for exactly one rising edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, b);
    {m_hi, m_lo} = model(op, a, b, m_hi, m_lo);
    start = 1'b1; HiLoOp = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; HiLoOp = OP_NOP;
  endtask

  // Counts remaining busy cycles (bounded) and samples done when busy drops.
  task automatic measure(output int cyc, output bit done_seen, output bit done_early);
    cyc = 0; done_early = 0;
    while (busy === 1'b1 && cyc < 64) begin
      if (done === 1'b1) done_early = 1;
      cyc++;
      @(negedge clk);
    end
    done_seen = (done === 1'b1);
  endtask

  task automatic read_hilo(output logic [31:0] hi, lo);
    HiLoOp = OP_MFHI; #1 hi = C;
    HiLoOp = OP_MFLO; #1 lo = C;
    HiLoOp = OP_NOP;
  endtask

  task automatic test_reset;
    logic [31:0] hi, lo;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || state !== 1'b0) begin
      n_bad++; $display("FAIL reset_ctrl: busy=%b done=%b state=%b want 0 0 0", busy, done, state);
    end
    read_hilo(hi, lo);
    n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin
      n_bad++; $display("FAIL reset_hilo: hi=%h lo=%h want 0 0", hi, lo);
    end
    n_cmp++; if (C !== 32'h0) begin
      n_bad++; $display("FAIL reset_c: C=%h want 0", C);
    end
  endtask

  task automatic test_mult;
    logic [3:0]  ops [6] = '{OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    logic [31:0] exp_hi [2] = '{32'hFFFF_FFFF, 32'h0000_0002};
    logic [3:0]  op;
    logic [31:0] hi, lo;
    int cyc; bit dn, early;
    for (int i = 0; i < 2; i++) begin
      op = (i == 0) ? OP_MULT : OP_MULTU;
      issue(op, 32'hFFFF_FFFE, 32'd3);
      measure(cyc, dn, early);
      read_hilo(hi, lo);
      n_cmp++; if (cyc !== LAT_MUL || !dn || early) begin
        n_bad++; $display("FAIL mult_timing[%0d]: busy=%0d done=%b early=%b want %0d 1 0", i, cyc, dn, early, LAT_MUL);
      end
      n_cmp++; if (hi !== exp_hi[i] || lo !== 32'hFFFF_FFFA) begin
        n_bad++; $display("FAIL mult_vec[%0d]: hi=%h lo=%h want %h fffffffa", i, hi, lo, exp_hi[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      op = ops[$urandom_range(0, 5)];
      issue(op, $urandom, $urandom);
      measure(cyc, dn, early);
      read_hilo(hi, lo);
      n_cmp++; if (cyc !== LAT_MUL || !dn || hi !== m_hi || lo !== m_lo) begin
        n_bad++; $display("FAIL mult_rand[%0d] op=%0d: busy=%0d done=%b hi=%h lo=%h want %0d 1 %h %h",
                          i, op, cyc, dn, hi, lo, LAT_MUL, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_div;
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [31:0] va [3] = '{32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
    logic [31:0] vb [3] = '{32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] vh [3] = '{32'hFFFF_FFFF, 32'd5, 32'h0};
    logic [31:0] vl [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    int cyc; bit dn, early;
    for (int i = 0; i < 3; i++) begin
      op = (i == 1) ? OP_DIVU : OP_DIV;
      issue(op, va[i], vb[i]);
      measure(cyc, dn, early);
      read_hilo(hi, lo);
      n_cmp++; if (cyc !== LAT_DIV || !dn || early) begin
        n_bad++; $display("FAIL div_timing[%0d]: busy=%0d done=%b early=%b want %0d 1 0", i, cyc, dn, early, LAT_DIV);
      end
      n_cmp++; if (hi !== vh[i] || lo !== vl[i]) begin
        n_bad++; $display("FAIL div_vec[%0d]: hi=%h lo=%h want %h %h", i, hi, lo, vh[i], vl[i]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      op = $urandom_range(0, 1) ? OP_DIV : OP_DIVU;
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 9);
        2:       b = -$urandom_range(1, 9);
        default: b = $urandom;
      endcase
      issue(op, a, b);
      measure(cyc, dn, early);
      read_hilo(hi, lo);
      n_cmp++; if (cyc !== LAT_DIV || !dn || hi !== m_hi || lo !== m_lo) begin
        n_bad++; $display("FAIL div_rand[%0d] op=%0d a=%h b=%h: busy=%0d done=%b hi=%h lo=%h want %0d 1 %h %h",
                          i, op, a, b, cyc, dn, hi, lo, LAT_DIV, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_accumulate;
    logic [31:0] hi, lo;
    int cyc; bit dn, early;
    issue(OP_MTHI, 32'h0, 32'h0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL mtx_busy: busy=%b want 0", busy);
    end
    read_hilo(hi, lo);
    n_cmp++; if (hi !== 32'h0 || lo !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL mtx_write: hi=%h lo=%h want 0 ffffffff", hi, lo);
    end
    issue(OP_MADDU, 32'd1, 32'd1);
    measure(cyc, dn, early);
    read_hilo(hi, lo);
    n_cmp++; if (cyc !== LAT_MUL || !dn || hi !== 32'h1 || lo !== 32'h0) begin
      n_bad++; $display("FAIL maddu: busy=%0d done=%b hi=%h lo=%h want %0d 1 1 0", cyc, dn, hi, lo, LAT_MUL);
    end
    issue(OP_MSUB, 32'd1, 32'd1);
    measure(cyc, dn, early);
    read_hilo(hi, lo);
    n_cmp++; if (cyc !== LAT_MUL || !dn || hi !== 32'h0 || lo !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL msub: busy=%0d done=%b hi=%h lo=%h want %0d 1 0 ffffffff", cyc, dn, hi, lo, LAT_MUL);
    end
  endtask

  task automatic test_flush;
    logic [31:0] hi, lo;
    bit seen;
    issue(OP_MTHI, 32'h11, 32'h0);
    issue(OP_MTLO, 32'h11, 32'h0);
    start = 1'b1; HiLoOp = OP_MULT; A = 32'd2; B = 32'd3;
    @(negedge clk);
    start = 1'b0; HiLoOp = OP_NOP;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL flush_mid: busy=%b done=%b want 0 0", busy, done);
    end
    seen = 0;
    repeat (8) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) seen = 1; end
    read_hilo(hi, lo);
    n_cmp++; if (seen || hi !== 32'h11 || lo !== 32'h11) begin
      n_bad++; $display("FAIL flush_mid_hilo: late_activity=%b hi=%h lo=%h want 0 11 11", seen, hi, lo);
    end
    // Flush in the final busy cycle must still cancel the commit.
    start = 1'b1; HiLoOp = OP_DIVU; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0; HiLoOp = OP_NOP;
    repeat (LAT_DIV - 1) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin
      n_bad++; $display("FAIL flush_last_busy: busy=%b want 1", busy);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    read_hilo(hi, lo);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h11 || lo !== 32'h11) begin
      n_bad++; $display("FAIL flush_last: busy=%b done=%b hi=%h lo=%h want 0 0 11 11", busy, done, hi, lo);
    end
    start = 1'b1; HiLoOp = OP_MULT; A = 32'd4; B = 32'd5; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; HiLoOp = OP_NOP; flush = 1'b0;
    seen = 0;
    repeat (LAT_MUL + 2) begin if (busy !== 1'b0 || done !== 1'b0) seen = 1; @(negedge clk); end
    read_hilo(hi, lo);
    n_cmp++; if (seen || hi !== 32'h11 || lo !== 32'h11) begin
      n_bad++; $display("FAIL flush_same_cycle: activity=%b hi=%h lo=%h want 0 11 11", seen, hi, lo);
    end
  endtask

  task automatic test_ignored;
    logic [31:0] hi, lo;
    int cyc; bit dn, early;
    issue(OP_MULTU, $urandom, $urandom);
    start = 1'b1; HiLoOp = OP_DIVU; A = $urandom; B = 32'd7;
    @(negedge clk);
    HiLoOp = OP_MTLO; A = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; HiLoOp = OP_NOP;
    measure(cyc, dn, early);
    read_hilo(hi, lo);
    n_cmp++; if (cyc + 2 !== LAT_MUL || !dn) begin
      n_bad++; $display("FAIL ignored_timing: busy=%0d done=%b want %0d 1", cyc + 2, dn, LAT_MUL);
    end
    n_cmp++; if (hi !== m_hi || lo !== m_lo) begin
      n_bad++; $display("FAIL ignored_result: hi=%h lo=%h want %h %h", hi, lo, m_hi, m_lo);
    end
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL ignored_after: busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  ops [4] = '{OP_DIV, OP_MADD, OP_DIVU, OP_MSUBU};
    logic [31:0] a, b, hi, lo;
    int cyc; bit dn, early;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 5));
      {m_hi, m_lo} = model(ops[i], a, b, m_hi, m_lo);
      start = 1'b1; HiLoOp = ops[i]; A = a; B = b;
      #1;
      n_cmp++; if (state !== 1'b1 || busy !== 1'b0) begin
        n_bad++; $display("FAIL b2b_issue[%0d]: state=%b busy=%b want 1 0", i, state, busy);
      end
      @(negedge clk);
      start = 1'b0; HiLoOp = OP_NOP;
      measure(cyc, dn, early);
      read_hilo(hi, lo);
      n_cmp++; if (cyc !== latency(ops[i]) || !dn || hi !== m_hi || lo !== m_lo) begin
        n_bad++; $display("FAIL b2b[%0d] op=%0d: busy=%0d done=%b hi=%h lo=%h want %0d 1 %h %h",
                          i, ops[i], cyc, dn, hi, lo, latency(ops[i]), m_hi, m_lo);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [31:0] hi, lo;
    issue(OP_MTHI, 32'h1234, 32'h0);
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_ctrl: busy=%b done=%b want 0 0", busy, done);
    end
    read_hilo(hi, lo);
    n_cmp++; if (hi !== 32'h0 || lo !== 32'h0 || C !== 32'h0) begin
      n_bad++; $display("FAIL reset_mid_hilo: hi=%h lo=%h C=%h want 0 0 0", hi, lo, C);
    end
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (LAT_DIV + 2) @(negedge clk);
    read_hilo(hi, lo);
    n_cmp++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_bad++; $display("FAIL reset_mid_after: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; start = 1'b0;
    HiLoOp = OP_NOP; A = '0; B = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_accumulate();
    test_flush();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit with private HI/LO registers, successor to the fixed 32-bit multdiv used in the EX stage. Accepts one operation per start pulse, holds `busy` for a configurable latency, and commits results to HI/LO on completion. Adds over the previous generation:
- width parameter;
- separate multiply and divide latencies;
- accumulate modes (MADD/MSUB);
- defined divide-by-zero and overflow results;
- a working flush/cancel path.

It sits in EX beside the ALU; its `C` output feeds the ALU-out mux.

## Interface
Parameters:
- `W`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU/MADD*/MSUB*. Must be at least 1.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU. Must be at least 1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `flush`  in  1  cancel any in-flight operation; suppresses `start` in the same cycle.
- `start`  in  1  `HiLoOp` is valid this cycle.
- `HiLoOp`  in  4  operation code (package `md_pkg`).
- `A`, `B`  in  W  operands (rs, rt).
- `C`  out  W  MFHI → HI, MFLO → LO, otherwise 0; combinational from `HiLoOp` and registers.
- `busy`  out  1  operation in flight.
- `state`  out  1  `busy | (start & is_long_op(HiLoOp))`; used by hazard logic to stall in the issue cycle.
- `done`  out  1  one-cycle pulse in the first cycle that new HI/LO values are visible.

## Operation
Opcodes: NOP, MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO, MFHI, MFLO.

- **Issue.** `start` with a long op is accepted only if `busy=0` and `flush=0`. Otherwise it is ignored; the pipeline guarantees a stall.
- **Result capture.** On acceptance the result is computed combinationally from A/B (and from HI/LO for accumulate ops) into pending registers `pend_hi`/`pend_lo`. A latency counter is loaded with MULT_CYCLES or DIV_CYCLES.
- **Multiply.** The 2W-bit product is signed or unsigned per opcode. HI takes the upper W bits, LO the lower W bits.
- **Accumulate.** MADD/MSUB form {HI,LO} ± product, modulo 2^(2W).
- **Divide.** LO = quotient, HI = remainder, truncating toward zero; the remainder takes the sign of the dividend.
- **Divide by zero** (signed or unsigned): LO = all-ones, HI = A.
- **Signed overflow** (A = most-negative, B = −1): LO = A, HI = 0.
- **MTHI/MTLO.** Write A to HI/LO at the edge. They do not assert `busy`, and are ignored while `busy=1`.
- **MFHI/MFLO.** Read the committed registers only, never the pending values.
- **Flush.** `flush=1` while busy returns to IDLE at the next edge. Pending values are discarded, HI/LO are unchanged, and `done` is not pulsed.

State machine, states IDLE, MUL, DIV:
- IDLE → MUL or DIV on an accepted start.
- MUL/DIV → IDLE when the counter reaches 1, or on flush.
- The counter decrements every cycle while in MUL/DIV.

Reset: all of the following are 0, and `C` is therefore 0: state=IDLE, counter, HI, LO, pend_hi, pend_lo, busy, done. Reset asserted mid-operation aborts the operation with no commit.

## Timing
- Start is sampled at edge t. `busy=1` during cycles t+1 … t+N, where N is the latency for the op.
- HI/LO commit at the edge ending cycle t+N.
- In cycle t+N+1: `busy=0`, `done=1`, and MFHI/MFLO return the new values.
- A new long op may be started in cycle t+N+1, giving back-to-back throughput of one op per N+1 cycles.
- Flush asserted in cycle k, where t+1 ≤ k ≤ t+N: `busy=0` from cycle k+1 and there is no commit. Flush in cycle t+N itself also cancels the commit.
- MTHI/MTLO take effect at the sampling edge and are visible the next cycle.

## Structure
- Package `md_pkg` holds:
  - the 4-bit opcode localparams;
  - the state enum (IDLE/MUL/DIV);
  - the function `is_long_op`.
- One sub-module, `md_compute`, is purely combinational. It maps (op, A, B, HI, LO) to (pend_hi, pend_lo) and contains all signed/unsigned, divide-by-zero and overflow rules.
- `md_unit` holds the registers, counter, FSM and output mux.

## Test plan
All scenarios use W=32, MULT_CYCLES=5, DIV_CYCLES=10.
1. **Signed multiply.** MULT A=0xFFFFFFFE, B=3 → busy for 5 cycles; then done, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
2. **Signed divide.** DIV A=−7 (0xFFFFFFF9), B=2 → busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. **Divide corner cases.**
   - DIVU A=5, B=0 → LO=0xFFFFFFFF, HI=5.
   - DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
4. **Accumulate.** MTHI 0, MTLO 0xFFFFFFFF, then MADDU A=1, B=1 → HI=1, LO=0. Next, MSUB A=1, B=1 → HI=0, LO=0xFFFFFFFF.
5. **Flush.** MULT A=2, B=3 with HI=LO=0x11 beforehand; flush in busy cycle 3 → busy=0 the next cycle, no done, HI=LO=0x11. Start+flush in the same cycle → never busy.
6. **Reset and ignored starts.**
   - Reset asserted mid-DIV → asynchronously busy=0, HI=LO=0, C=0.
   - A start issued while busy is ignored; the original result is unchanged.
   - MTLO while busy is ignored.
